// File: rtl/msg_tx_arbiter_if.sv
// Handshake bundle between the requesters, the message arbiter and the UART
// message buffer.
interface msg_tx_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int NREQ       = 3,
    parameter int IDW        = 2
);
    localparam int MW = 2 * (ADDR_WIDTH + 1) + 4;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*MW-1:0] req_msg;
    logic [NREQ-1:0]    req_ack;
    logic               tx_valid;
    logic [MW-1:0]      tx_message;
    logic               tx_ack;
    logic [IDW-1:0]     grant_id;
    logic               busy;

    // master: the arbiter itself
    modport master (
        input  req_valid, req_msg, tx_ack,
        output req_ack, tx_valid, tx_message, grant_id, busy
    );

    // slave: requesters plus the downstream buffer
    modport slave (
        output req_valid, req_msg, tx_ack,
        input  req_ack, tx_valid, tx_message, grant_id, busy
    );
endinterface

// File: rtl/msg_tx_arbiter.sv
// Round-robin arbiter sharing one outbound message channel among NREQ requesters.
// Define MSG_ARB_PRIORITY_EN to give requester 0 strict priority over the rest.
module msg_tx_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int NREQ       = 3,
    parameter int IDW        = 2
) (
    input  logic             clk,
    input  logic             rst,
    msg_tx_arbiter_if.master bus
);
    localparam int MW = 2 * (ADDR_WIDTH + 1) + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            tx_valid_q, tx_valid_d;
    logic [MW-1:0]   tx_message_q, tx_message_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  last_q, last_d;

    logic            any_req;
    logic [IDW-1:0]  winner;
    int              idx;

    // Winner search starts just after the last grantee, so it has lowest priority.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
`ifdef MSG_ARB_PRIORITY_EN
        // last_q only ever holds 1..NREQ-1 here: requester 0 bypasses the ring.
        if (bus.req_valid[0]) begin
            any_req = 1'b1;
        end else begin
            for (int k = 1; k < NREQ; k++) begin
                idx = 1 + ((int'(last_q) - 1 + k) % (NREQ - 1));
                if (!any_req && |(bus.req_valid & (NREQ'(1) << idx))) begin
                    any_req = 1'b1;
                    winner  = IDW'(idx);
                end
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!any_req && |(bus.req_valid & (NREQ'(1) << idx))) begin
                any_req = 1'b1;
                winner  = IDW'(idx);
            end
        end
`endif
    end

    // NOTE: every target gets a default before the case so no path leaves a
    // signal unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d      = state_q;
        tx_valid_d   = tx_valid_q;
        tx_message_d = tx_message_q;
        req_ack_d    = '0;
        grant_id_d   = grant_id_q;
        last_d       = last_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = OFFER;
                    tx_valid_d   = 1'b1;
                    tx_message_d = MW'(bus.req_msg >> (int'(winner) * MW));
                    grant_id_d   = winner;
`ifdef MSG_ARB_PRIORITY_EN
                    if (winner != '0) last_d = winner;
`else
                    last_d = winner;
`endif
                end
            end
            OFFER: begin
                if (bus.tx_ack) begin
                    state_d    = GAP;
                    tx_valid_d = 1'b0;
                    req_ack_d  = NREQ'(1) << grant_id_q;
                end
            end
            // One dead cycle so the buffer never sees back-to-back valids.
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_valid_q   <= 1'b0;
            tx_message_q <= '0;
            req_ack_q    <= '0;
            grant_id_q   <= '0;
            last_q       <= IDW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            tx_valid_q   <= tx_valid_d;
            tx_message_q <= tx_message_d;
            req_ack_q    <= req_ack_d;
            grant_id_q   <= grant_id_d;
            last_q       <= last_d;
        end
    end

    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_message = tx_message_q;
    assign bus.req_ack    = req_ack_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Self-checking bench for msg_tx_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level arbitration model.
module tb_msg_tx_arbiter;
    localparam int ADDR_WIDTH = 4;
    localparam int NREQ       = 3;
    localparam int IDW        = 2;
    localparam int MW         = 2 * (ADDR_WIDTH + 1) + 4;

    logic clk;
    logic rst;

    msg_tx_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    msg_tx_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side view and reference-model state.
    logic [NREQ-1:0] pending;
    logic [MW-1:0]   msgs [NREQ];
    int              m_last;
    int              m_last_rr;
    int              m_gid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) bus.req_msg[i*MW +: MW] = msgs[i];
        bus.req_valid = pending;
    endtask

    task automatic model_reset();
        m_last    = NREQ - 1;
        m_last_rr = NREQ - 1;
        m_gid     = 0;
    endtask

    // Spec rule: first pending requester strictly after the last grantee, with wrap.
    function automatic int model_pick(input logic [NREQ-1:0] m);
`ifdef MSG_ARB_PRIORITY_EN
        int i;
        if (m[0]) return 0;
        for (int k = 1; k < NREQ; k++) begin
            i = 1 + ((m_last_rr - 1 + k) % (NREQ - 1));
            if (m[i]) return i;
        end
        return -1;
`else
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (m_last + k) % NREQ;
            if (m[i]) return i;
        end
        return -1;
`endif
    endfunction

    task automatic model_grant(input int w);
        m_gid = w;
`ifdef MSG_ARB_PRIORITY_EN
        if (w != 0) m_last_rr = w;
`else
        m_last = w;
`endif
    endtask

    task automatic add_random(input logic [NREQ-1:0] excl);
        logic [NREQ-1:0] r;
        r = NREQ'($urandom) & NREQ'($urandom) & ~pending & ~excl;
        for (int i = 0; i < NREQ; i++) if (r[i]) msgs[i] = MW'($urandom);
        pending = pending | r;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_msg"},   32'(bus.tx_message), 32'd0);
        check({tag, "_ack"},   32'(bus.req_ack), 32'd0);
        check({tag, "_gid"},   32'(bus.grant_id), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
    endtask

    // Async reset applied mid-cycle; tx_ack held high to show it cannot leak an ack.
    task automatic apply_reset();
        rst         = 1'b1;
        pending     = '0;
        bus.tx_ack  = 1'b1;
        drive();
        #1;
        check_zero_outputs("rst");
        tick();
        check("rst_no_ack", 32'(bus.req_ack), 32'd0);
        check("rst_hold_valid", 32'(bus.tx_valid), 32'd0);
        #2;
        rst        = 1'b0;
        bus.tx_ack = 1'b0;
        model_reset();
        tick();
        check_zero_outputs("post_rst");
    endtask

    task automatic idle(input int n, input bit force_ack);
        for (int c = 0; c < n; c++) begin
            bus.tx_ack = force_ack | 1'($urandom_range(0, 1));
            drive();
            tick();
            check("idle_valid", 32'(bus.tx_valid), 32'd0);
            check("idle_ack",   32'(bus.req_ack), 32'd0);
            check("idle_busy",  32'(bus.busy), 32'd0);
            check("idle_gid",   32'(bus.grant_id), 32'(m_gid));
        end
        bus.tx_ack = 1'b0;
    endtask

    // One full grant: IDLE -> OFFER (hold cycles) -> GAP -> IDLE.
    task automatic serve(input int hold, input bit withdraw, input bit change,
                         input logic [MW-1:0] new_msg, input bit rnd, output int got);
        int            w;
        logic [MW-1:0] exp_msg;
        w       = model_pick(pending);
        exp_msg = msgs[w];
        bus.tx_ack = 1'b0;
        drive();
        tick();
        model_grant(w);
        got = int'(bus.grant_id);
        check("grant_valid", 32'(bus.tx_valid), 32'd1);
        check("grant_id",    32'(bus.grant_id), 32'(w));
        check("grant_msg",   32'(bus.tx_message), 32'(exp_msg));
        check("grant_busy",  32'(bus.busy), 32'd1);
        check("grant_noack", 32'(bus.req_ack), 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (h == 0 && withdraw) pending[w] = 1'b0;
            if (h == 0 && change)   msgs[w] = new_msg;
            if (rnd) add_random(NREQ'(1) << w);
            drive();
            tick();
            check("offer_valid", 32'(bus.tx_valid), 32'd1);
            check("offer_msg",   32'(bus.tx_message), 32'(exp_msg));
            check("offer_noack", 32'(bus.req_ack), 32'd0);
        end
        bus.tx_ack = 1'b1;
        drive();
        tick();
        check("gap_valid", 32'(bus.tx_valid), 32'd0);
        check("gap_ack",   32'(bus.req_ack), 32'(NREQ'(1) << w));
        check("gap_busy",  32'(bus.busy), 32'd1);
        check("gap_msg",   32'(bus.tx_message), 32'(exp_msg));
        pending[w] = 1'b0;
        if (rnd) add_random(NREQ'(1) << w);
        bus.tx_ack = 1'($urandom_range(0, 1));
        drive();
        tick();
        check("back_ack",   32'(bus.req_ack), 32'd0);
        check("back_valid", 32'(bus.tx_valid), 32'd0);
        check("back_busy",  32'(bus.busy), 32'd0);
        check("back_gid",   32'(bus.grant_id), 32'(w));
        bus.tx_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int got;
        for (int i = 0; i < NREQ; i++) msgs[i] = '0;
        pending    = '0;
        bus.tx_ack = 1'b0;
        model_reset();
        apply_reset();

        // Single requester, ack two cycles after tx_valid.
        pending = 3'b001;
        msgs[0] = 14'h1A5;
        serve(2, 1'b0, 1'b0, '0, 1'b0, got);
        check("first_grant", 32'(got), 32'd0);

        // tx_ack while idle is ignored.
        idle(3, 1'b1);

        // Message change after grant must not reach tx_message.
        pending = 3'b010;
        msgs[1] = 14'h0042;
        serve(2, 1'b0, 1'b1, 14'h3FFF, 1'b0, got);
        check("latch_grant", 32'(got), 32'd1);

        apply_reset();
`ifdef MSG_ARB_PRIORITY_EN
        // Requester 0 preempts the ring; 1 and 2 keep rotating.
        pending = 3'b110;
        serve(0, 1'b0, 1'b0, '0, 1'b0, got);
        check("prio_order0", 32'(got), 32'd1);
        pending = pending | 3'b111;
        serve(0, 1'b0, 1'b0, '0, 1'b0, got);
        check("prio_order1", 32'(got), 32'd0);
        pending = pending | 3'b110;
        serve(0, 1'b0, 1'b0, '0, 1'b0, got);
        check("prio_order2", 32'(got), 32'd2);
        pending = pending | 3'b110;
        serve(0, 1'b0, 1'b0, '0, 1'b0, got);
        check("prio_order3", 32'(got), 32'd1);
        pending = '0;
        idle(1, 1'b0);
`else
        // All requesters held valid, immediate acks: 0,1,2,0,1,2.
        for (int r = 0; r < 6; r++) begin
            pending = '1;
            serve(0, 1'b0, 1'b0, '0, 1'b0, got);
            check("rr_order", 32'(got), 32'(r % NREQ));
        end
        pending = '0;
        idle(1, 1'b0);
`endif

        // Reset in the middle of an OFFER to requester 2.
        pending = 3'b100;
        msgs[2] = MW'($urandom);
        drive();
        tick();
        check("pre_rst_gid", 32'(bus.grant_id), 32'd2);
        check("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
        #2;
        apply_reset();
        pending = '1;
        serve(0, 1'b0, 1'b0, '0, 1'b0, got);
        check("after_rst_grant", 32'(got), 32'd0);
        while (pending != '0) serve($urandom_range(0, 2), 1'b0, 1'b0, '0, 1'b0, got);

        // Randomized traffic against the model.
        for (int t = 0; t < 200; t++) begin
            add_random('0);
            if (pending == '0) idle($urandom_range(1, 3), 1'b0);
            else serve($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), MW'($urandom), 1'b1, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
